// File: rtl/if_stage_pkg.sv
// Shared CPU definitions: PC type, instruction constants and the IF/ID payload.
package if_stage_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef logic [XLEN-1:0] pc_t;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
    localparam pc_t             DEFAULT_RESET_PC = 32'h0000_0000;

    // IF/ID pipeline register payload
    typedef struct packed {
        logic [XLEN-1:0] instr;
        pc_t             pc4;
        logic            valid;
    } ifid_t;

    // Bubble contents, also the reset contents of the register
    localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc4: '0, valid: 1'b0};

endpackage

// File: rtl/if_stage_ifid_reg.sv
// IF/ID pipeline register with flush-over-stall priority.
// Ports: clk, rst (sync, active-high), stall (hold contents),
//        flush (load bubble), d (next payload), q (registered payload).
module ifid_reg
    import if_stage_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  stall,
    input  logic  flush,
    input  ifid_t d,
    output ifid_t q
);

    // Reset and flush both leave a bubble; flush wins over stall
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            q <= IFID_BUBBLE;
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction memory,
// captures the fetched instruction into IF/ID and counts valid fetches.
// Ports: i_clk, i_rst (sync, active-high), i_stall, i_flush, i_redirect,
//        i_redirect_pc, i_instr (memory data for o_pc), o_pc, o_ifid_instr,
//        o_ifid_pc4, o_ifid_valid, o_pc_oob (combinational), o_misalign
//        (sticky), o_fetch_count.
module if_stage
    import if_stage_pkg::*;
#(
    parameter pc_t         RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned IMEM_BYTES = 800
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_pc,
    input  logic [31:0] i_instr,
    output logic [31:0] o_ifid_instr,
    output logic [31:0] o_ifid_pc4,
    output logic        o_ifid_valid,
    output logic        o_pc_oob,
    output logic        o_misalign,
    output logic [31:0] o_fetch_count
);

    pc_t   pc;
    pc_t   pc_next;
    pc_t   pc_plus4;
    ifid_t ifid_d;
    ifid_t ifid_q;
    logic  load;

    assign pc_plus4 = pc + XLEN'(INSTR_BYTES);
    assign load     = !i_flush && !i_stall;

    // Next-PC priority: redirect, then stall, then sequential
    always_comb begin
        pc_next = pc_plus4;
        if (i_redirect) begin
            pc_next = {i_redirect_pc[31:2], 2'b00};
        end else if (i_stall) begin
            pc_next = pc;
        end
    end

    // PC, sticky misalignment flag and fetch counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc            <= RESET_PC;
            o_misalign    <= 1'b0;
            o_fetch_count <= '0;
        end else begin
            pc <= pc_next;
            if (i_redirect && (i_redirect_pc[1:0] != 2'b00)) begin
                o_misalign <= 1'b1;
            end
            if (load) begin
                o_fetch_count <= o_fetch_count + 32'd1;
            end
        end
    end

    assign ifid_d = '{instr: i_instr, pc4: pc_plus4, valid: 1'b1};

    ifid_reg u_ifid_reg (
        .clk   (i_clk),
        .rst   (i_rst),
        .stall (i_stall),
        .flush (i_flush),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    // Evaluated in 33 bits so a PC near the top of the address space still reports
    assign o_pc_oob = (33'(pc) + 33'(INSTR_BYTES)) > 33'(IMEM_BYTES);

    assign o_pc         = pc;
    assign o_ifid_instr = ifid_q.instr;
    assign o_ifid_pc4   = ifid_q.pc4;
    assign o_ifid_valid = ifid_q.valid;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        pc_oob;
    logic        misalign;
    logic [31:0] fetch_count;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model state: what the stage must hold after each edge
    logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
    logic        m_valid, m_mis;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(32'h0), .IMEM_BYTES(800)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_stall       (stall),
        .i_flush       (flush),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_pc          (pc),
        .i_instr       (instr),
        .o_ifid_instr  (ifid_instr),
        .o_ifid_pc4    (ifid_pc4),
        .o_ifid_valid  (ifid_valid),
        .o_pc_oob      (pc_oob),
        .o_misalign    (misalign),
        .o_fetch_count (fetch_count)
    );

    // Instruction memory contents as seen by the fetch stage
    function automatic logic [31:0] imem(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        if (a == 32'h4) return 32'h2009_0003;
        return {16'hA000, a[15:0]};
    endfunction

    always_comb instr = imem(pc);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of one clock edge
    task automatic model_step(input logic r, input logic s, input logic f,
                              input logic rd, input logic [31:0] rpc);
        if (r) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
            m_valid = 1'b0; m_mis = 1'b0; m_cnt = 32'h0;
            return;
        end
        if (f) begin
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (!s) begin
            m_instr = imem(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
            m_cnt = m_cnt + 32'd1;
        end
        if (rd) begin
            m_pc = rpc & 32'hFFFF_FFFC;
            if (rpc % 4 != 0) m_mis = 1'b1;
        end else if (!s) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc", pc, m_pc);
            chk("ifid_instr", ifid_instr, m_instr);
            chk("ifid_pc4", ifid_pc4, m_pc4);
            chk("ifid_valid", 32'(ifid_valid), 32'(m_valid));
            chk("misalign", 32'(misalign), 32'(m_mis));
            chk("fetch_count", fetch_count, m_cnt);
            chk("pc_oob", 32'(pc_oob), 32'((longint'(m_pc) + 4) > 800));
        end
    end

    task automatic cyc(input logic r, input logic s, input logic f,
                       input logic rd, input logic [31:0] rpc);
        rst = r; stall = s; flush = f; redirect = rd; redirect_pc = rpc;
        @(posedge clk);
        model_step(r, s, f, rd, rpc);
        @(negedge clk);
        #1;
    endtask

    initial begin
        @(negedge clk);
        // Reset, with a pending redirect that must be discarded
        cyc(1, 0, 0, 1, 32'h100);
        chk_en = 1'b1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", 32'(ifid_valid), 32'h0);
        chk("rst_instr", ifid_instr, 32'h0);
        chk("rst_count", fetch_count, 32'h0);
        chk("rst_mis", 32'(misalign), 32'h0);

        // Sequential fetch
        cyc(0, 0, 0, 0, 0);
        chk("seq1_instr", ifid_instr, 32'h2008_0005);
        chk("seq1_pc4", ifid_pc4, 32'h4);
        chk("seq1_pc", pc, 32'h4);
        cyc(0, 0, 0, 0, 0);
        chk("seq2_instr", ifid_instr, 32'h2009_0003);
        chk("seq2_pc4", ifid_pc4, 32'h8);

        // Stall two cycles at PC 8
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("stall_pc", pc, 32'h8);
        chk("stall_instr", ifid_instr, 32'h2009_0003);
        chk("stall_count", fetch_count, 32'd2);
        cyc(0, 0, 0, 0, 0);
        chk("resume_pc", pc, 32'hC);
        chk("resume_count", fetch_count, 32'd3);

        // Redirect with flush at PC 12
        cyc(0, 0, 1, 1, 32'h40);
        chk("redir_pc", pc, 32'h40);
        chk("redir_valid", 32'(ifid_valid), 32'h0);
        chk("redir_instr", ifid_instr, 32'h0);
        chk("redir_count", fetch_count, 32'd3);
        cyc(0, 0, 0, 0, 0);
        chk("target_instr", ifid_instr, 32'hA000_0040);
        chk("target_pc4", ifid_pc4, 32'h44);

        // Misaligned redirect; flag is sticky
        cyc(0, 0, 0, 1, 32'h42);
        chk("mis_pc", pc, 32'h40);
        chk("mis_set", 32'(misalign), 32'h1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("mis_sticky", 32'(misalign), 32'h1);
        chk("mis_count", fetch_count, 32'd7);

        // Stall+flush+redirect, then stall+flush alone
        cyc(0, 0, 0, 1, 32'h20);
        cyc(0, 1, 1, 1, 32'h80);
        chk("sfr_pc", pc, 32'h80);
        chk("sfr_valid", 32'(ifid_valid), 32'h0);
        cyc(0, 1, 1, 0, 0);
        chk("sf_pc", pc, 32'h80);
        chk("sf_valid", 32'(ifid_valid), 32'h0);
        chk("sf_count", fetch_count, 32'd8);

        // Out-of-range boundary around 800
        cyc(0, 0, 0, 1, 32'd792);
        cyc(0, 0, 0, 0, 0);
        chk("oob_796", 32'(pc_oob), 32'h0);
        cyc(0, 0, 0, 0, 0);
        chk("oob_800_pc", pc, 32'd800);
        chk("oob_800", 32'(pc_oob), 32'h1);

        // PC wrap at 2^32
        cyc(0, 0, 0, 1, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0, 0);
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_pc4", ifid_pc4, 32'h0);

        // Reset while stalling with a redirect pending
        cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 0, 1, 32'h200);
        chk("rst2_pc", pc, 32'h0);
        chk("rst2_count", fetch_count, 32'h0);
        chk("rst2_mis", 32'(misalign), 32'h0);
        cyc(0, 0, 0, 0, 0);
        chk("post_rst_instr", ifid_instr, 32'h2008_0005);
        chk("post_rst_count", fetch_count, 32'd1);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined MIPS CPU.
- Owns the PC register and drives the byte address into the combinational instruction memory.
- Captures the returned 32-bit big-endian instruction into the IF/ID pipeline register.
- Honours stall (load-use hazard), flush and redirect (branch/jump) requests from the ID/hazard unit, and keeps a fetch counter for debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_BYTES, 800, highest legal byte count of instruction memory; fetches beyond it are flagged.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_stall  input  1  hold PC and IF/ID contents this cycle.
- i_flush  input  1  load a bubble into IF/ID this cycle.
- i_redirect  input  1  load i_redirect_pc into PC this cycle.
- i_redirect_pc  input  32  branch/jump target byte address.
- o_pc  output  32  current PC; drives instruction memory address.
- i_instr  input  32  instruction returned by instruction memory for o_pc (same cycle).
- o_ifid_instr  output  32  IF/ID instruction register.
- o_ifid_pc4  output  32  IF/ID PC+4 register.
- o_ifid_valid  output  1  IF/ID holds a real instruction (0 = bubble).
- o_pc_oob  output  1  combinational: o_pc+4 > IMEM_BYTES.
- o_misalign  output  1  sticky: a redirect target had nonzero bits [1:0].
- o_fetch_count  output  32  number of valid instructions loaded into IF/ID.

Behaviour:
- Reset (i_rst=1 at edge, overrides everything):
  - PC=RESET_PC; o_ifid_instr=0; o_ifid_pc4=0; o_ifid_valid=0; o_misalign=0; o_fetch_count=0.
  - Reset mid-stall or mid-redirect discards the pending request.
- PC next-value priority: i_redirect > i_stall > sequential.
  - i_redirect: PC <= {i_redirect_pc[31:2],2'b00}. If i_redirect_pc[1:0]!=0, set o_misalign (cleared only by reset).
  - i_stall (no redirect): PC holds.
  - Otherwise: PC <= PC+4, wrapping modulo 2^32 with no flag.
- IF/ID update priority: i_flush > i_stall > load.
  - i_flush: instr <= 32'h0000_0000 (nop), pc4 <= 0, valid <= 0.
  - i_stall (no flush): all IF/ID fields hold.
  - Load: instr <= i_instr, pc4 <= PC+4, valid <= 1.
  - i_flush with i_stall: flush wins, bubble inserted. PC still follows its own priority (holds unless redirect).
  - Hazard unit normally asserts i_flush together with i_redirect; the block treats them independently.
- Latency: the instruction at address A is presented at o_pc in cycle n and appears in IF/ID after the edge ending cycle n, i.e. one cycle.
- The first edge after reset deasserts loads instr(RESET_PC) with valid=1.
- o_fetch_count increments by 1 on every IF/ID load with valid<=1. Wraps at 2^32. Does not increment on stall, flush or reset.
- o_pc_oob is informational only; fetch continues and the instruction returned is whatever memory provides.
- All outputs other than o_pc_oob are registered.

Decomposition:
- Shared CPU package: NOP_INSTR (32'h0), INSTR_BYTES (4), RESET_PC default, and a pc_t 32-bit typedef reused by ID/EX stages.
- One natural sub-module: ifid_reg (IF/ID pipeline register with flush/stall priority), reusable as the template for ID/EX, EX/MEM and MEM/WB.
- The PC and next-PC mux stay in if_stage.

Test Plan:
- Reset then 4 free cycles, i_instr driven as 0x20080005 at PC 0 and 0x20090003 at PC 4 → o_pc sequence 0,4,8,12,16; IF/ID gets 0x20080005/pc4=4 then 0x20090003/pc4=8; o_fetch_count=4.
- Stall for 2 cycles at PC=8 → o_pc stays 8, IF/ID holds the instruction from PC 4, count frozen; resumes at 12 on release.
- Redirect to 0x40 with flush at PC=12 → next o_pc=0x40, IF/ID valid=0 and instr=0, count unchanged; following cycle loads instr(0x40), pc4=0x44.
- Redirect to 0x42 → o_pc=0x40, o_misalign=1 and stays 1 across later cycles until i_rst.
- Stall+flush+redirect same cycle at PC=0x20 to 0x80 → o_pc=0x80, IF/ID bubble; stall+flush without redirect → PC holds, bubble.
- Sequential run up to PC=800 → o_pc_oob=1 when o_pc=800; i_rst asserted mid-stall → PC=0, all IF/ID and count cleared next edge.
